serial_alu_seq: RTL and testbench
=================================

Name: serial_alu_seq

Overview:
- Bit-serial sequencer that drives a single 1-bit ALU slice (AND/OR/ADD/SUB) to produce a WIDTH-bit result, LSB first, one bit per clock.
- Acts as the initiator side of the slice interface: it sources a, b, cin and op to the slice and collects result and cout from it.
- Accepts operand/op transactions on a valid/ready input handshake and returns the result, carry and zero flag on a valid/ready output handshake.
- Sits between a register file/controller and an externally instantiated slice; it is the area-cheap alternative to the parallel generate-based ALU.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  sequencer can accept a transaction.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (A-B).
- slice_a  output  1  current A bit to slice.
- slice_b  output  1  current B bit to slice (uninverted; the slice inverts for SUB).
- slice_cin  output  1  carry into slice.
- slice_op  output  2  op to slice.
- slice_result  input  1  slice result bit (combinational from slice_*).
- slice_cout  input  1  slice carry out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  assembled result.
- cout  output  1  final carry; for SUB, 1 = no borrow (A≥B unsigned); 0 for AND/OR.
- zero  output  1  result == 0.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; in_ready=1; out_valid=0; result=0; cout=0; zero=0; slice_a, slice_b, slice_cin=0; slice_op=00; bit counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b, op into shift registers and op_q.
  - Load carry_q = 1 when op=11 (two's-complement SUB), else 0.
  - Clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Drive slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry_q, slice_op=op_q.
  - Each edge:
    - Shift slice_result into the result register from the MSB side (right shift).
    - carry_q <= slice_cout.
    - Shift a_sh and b_sh right.
    - Counter increments.
  - After the WIDTH-th bit edge, go to DONE.
- DONE:
  - out_valid=1.
  - result is the assembled word, with bit i captured on RUN cycle i.
  - cout=carry_q when op_q is 10/11, else 0.
  - zero=(result==0).
  - Hold all outputs stable until out_ready=1. The edge with out_ready=1 returns to IDLE and clears out_valid.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge. Throughput is one transaction per WIDTH+2 cycles when out_ready is held high.
- Outside RUN, slice_a, slice_b and slice_cin are driven 0 and slice_op is driven 00.
- in_valid is ignored outside IDLE; no transaction is lost or double-accepted.
- Arithmetic is modulo 2^WIDTH. Intermediate carries are propagated only through carry_q; no lookahead.
- rst in any state, including mid-RUN: return to IDLE with reset values on the next edge. The partial result is discarded and not presented.
- Changes on a/b/op after acceptance have no effect.

Optional Feature:
- Macro: SERIAL_ALU_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit).
  - During the final RUN bit (MSB), capture carry_q (carry into MSB) into cin_msb_q.
  - In DONE, ovf = cin_msb_q XOR carry_q for op 10/11, and 0 for AND/OR.
  - ovf resets to 0 and clears with out_valid.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- ADD a=8'h3C b=8'h05, out_ready=1 -> out_valid exactly 8 clocks after acceptance; result=8'h41, cout=0, zero=0.
- ADD a=8'hFF b=8'h01 -> result=8'h00, cout=1, zero=1; with SERIAL_ALU_OVF_EN, ovf=0.
- SUB a=8'h05 b=8'h07 -> result=8'hFE, cout=0; then SUB a=8'h07 b=8'h05 -> result=8'h02, cout=1.
- AND a=8'hA5 b=8'h0F -> result=8'h05, cout=0; OR a=8'hA0 b=8'h0A -> result=8'hAA, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> result, cout and zero remain stable, in_ready=0, new operands are not accepted; after out_ready=1, in_ready=1 on the next cycle.
- Assert rst for one cycle during RUN bit 3 -> next cycle state IDLE, out_valid=0, in_ready=1, slice_op=00; with SERIAL_ALU_OVF_EN, a subsequent ADD 8'h7F+8'h01 -> result=8'h80, ovf=1.

Source files
------------

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial sequencer driving an external 1-bit ALU slice, LSB first
// Optional overflow flag output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_run;
    logic             w_done;
    logic             w_arith;
`ifdef SERIAL_ALU_OVF_EN
    logic             r_cin_msb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_RUN;
            S_RUN:  if (r_cnt == LAST_BIT) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand shifters, result assembly and the single ripple carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res     <= '0;
            r_op      <= 2'b00;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
`ifdef SERIAL_ALU_OVF_EN
            r_cin_msb <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= op;
                        r_carry <= (op == 2'b11);
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_res   <= {slice_result, r_res[WIDTH-1:1]};
                    r_carry <= slice_cout;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
`ifdef SERIAL_ALU_OVF_EN
                    if (r_cnt == LAST_BIT) r_cin_msb <= r_carry;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign w_run   = (r_state == S_RUN);
    assign w_done  = (r_state == S_DONE);
    assign w_arith = r_op[1];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = w_done;

    assign slice_a   = w_run & r_a_sh[0];
    assign slice_b   = w_run & r_b_sh[0];
    assign slice_cin = w_run & r_carry;
    assign slice_op  = w_run ? r_op : 2'b00;

    assign result = r_res;
    assign cout   = w_done & w_arith & r_carry;
    assign zero   = w_done & (r_res == '0);
`ifdef SERIAL_ALU_OVF_EN
    assign ovf    = w_done & w_arith & (r_cin_msb ^ r_carry);
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - directed table-driven bench for serial_alu_seq with a behavioural 1-bit slice
module tb_serial_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       slice_a;
    logic       slice_b;
    logic       slice_cin;
    logic [1:0] slice_op;
    logic       slice_result;
    logic       slice_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       zero;
`ifdef SERIAL_ALU_OVF_EN
    logic       ovf;
`endif
    logic       w_sb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_alu_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .slice_result (slice_result),
        .slice_cout   (slice_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .cout         (cout),
        .zero         (zero)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    // The external slice: inverts B for SUB, full adder for ADD/SUB.
    assign w_sb         = (slice_op == 2'b11) ? ~slice_b : slice_b;
    assign slice_result = slice_op[1] ? (slice_a ^ w_sb ^ slice_cin)
                                      : (slice_op[0] ? (slice_a | slice_b) : (slice_a & slice_b));
    assign slice_cout   = slice_op[1] & ((slice_a & w_sb) | (slice_a & slice_cin) | (w_sb & slice_cin));

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [1:0] vop;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        a = va; b = vb; op = vop; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~va; b = ~vb; op = ~vop;
        chk("run_slice_op", slice_op, vop);
        chk("run_slice_a0", slice_a, va[0]);
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic saw;

        vecs[0] = '{8'h3C, 8'h05, 2'b10, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 2'b11, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 8'h05, 2'b11, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'h0F, 2'b00, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hA0, 8'h0A, 2'b01, 8'hAA, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h05, 8'h05, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 0);
        chk("rst_slice_bits", {slice_a, slice_b, slice_cin}, 0);
        chk("rst_slice_op", slice_op, 0);
`ifdef SERIAL_ALU_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vop);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].c);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
`ifdef SERIAL_ALU_OVF_EN
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].v);
`endif
            finish_op();
            chk($sformatf("v%0d_valid_cleared", i), out_valid, 0);
        end

        // Backpressure in DONE with competing input traffic.
        start_op(8'h3C, 8'h05, 2'b10);
        wait_done(lat);
        chk("bp_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            a = 8'h11; b = 8'h22; op = 2'b01; in_valid = (k % 2 == 0);
            @(posedge clk); #1;
            chk("bp_result", result, 8'h41);
            chk("bp_cout", cout, 0);
            chk("bp_zero", zero, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        finish_op();
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        start_op(8'hA5, 8'h0F, 2'b00);
        wait_done(lat);
        chk("bp_next_result", result, 8'h05);
        finish_op();

        // Reset during RUN bit 3.
        start_op(8'h12, 8'h34, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_slice_op", slice_op, 0);
        chk("mid_rst_result", result, 0);
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            saw = saw | out_valid;
        end
        chk("mid_rst_no_stale_result", saw, 0);
        start_op(8'h7F, 8'h01, 2'b10);
        wait_done(lat);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_result", result, 8'h80);
        chk("post_rst_cout", cout, 0);
`ifdef SERIAL_ALU_OVF_EN
        chk("post_rst_ovf", ovf, 1);
`endif
        finish_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
